flappy_game_ctrl: RTL

//  Game-flow controller for tt_um_flappy_bird. Sequences IDLE/PLAY/DYING/OVER once per
//  VGA frame, turns up/down buttons (ui_in[0]/ui_in[1]) into bird velocity and position,

---
 rtl/flappy_game_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/flappy_game_ctrl.sv
// Game-flow controller: IDLE/PLAY/DYING/OVER sequencing once per frame,
// bird velocity/position, pipe scroll gating and a 2-digit BCD score.
module flappy_game_ctrl #(
  parameter int SCREEN_H     = 480,
  parameter int BIRD_H       = 16,
  parameter int START_Y      = 232,
  parameter int FLAP_VEL     = -6,
  parameter int GRAVITY      = 1,
  parameter int VMAX         = 8,
  parameter int DEATH_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       collide,
  input  logic       pipe_passed,
  output logic [9:0] bird_y,
  output logic       scroll_en,
  output logic [1:0] state,
  output logic [7:0] score,
  output logic       game_over,
  output logic       flash
);

  localparam int CNT_W = $clog2(DEATH_FRAMES + 1);

  localparam logic [9:0]        Y_MAX    = 10'(SCREEN_H - BIRD_H);
  localparam logic [9:0]        Y_START  = 10'(START_Y);
  localparam logic signed [5:0] V_FLAP   = 6'(FLAP_VEL);
  localparam logic signed [5:0] V_MAX    = 6'(VMAX);
  localparam logic signed [5:0] V_GRAV   = 6'(GRAVITY);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DEATH_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t                cur_state, nxt_state;
  logic signed [4:0]     vel, vel_n;
  logic [9:0]            y_n;
  logic [7:0]            score_n;
  logic [CNT_W-1:0]      cnt, cnt_n;

  logic [2:0]            up_sync, dn_sync;
  logic                  up_edge, dn_edge;
  logic                  up_pend, down_pend, col_pend, pass_pend;
  logic                  tick;

  logic signed [5:0]     vel_grav, vel_sel;
  logic signed [10:0]    y_sum;

  assign tick    = frame_tick & ena;
  assign up_edge = up_sync[1] & ~up_sync[2];
  assign dn_edge = dn_sync[1] & ~dn_sync[2];

  // Two-stage button synchronizers plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_sync <= '0;
      dn_sync <= '0;
    end else begin
      up_sync <= {up_sync[1:0], btn_up};
      dn_sync <= {dn_sync[1:0], btn_down};
    end
  end

  // Sticky per-frame event flags; an event in the tick cycle seeds the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_pend   <= 1'b0;
      down_pend <= 1'b0;
      col_pend  <= 1'b0;
      pass_pend <= 1'b0;
    end else if (tick) begin
      up_pend   <= up_edge;
      down_pend <= dn_edge;
      col_pend  <= collide;
      pass_pend <= pipe_passed;
    end else begin
      up_pend   <= up_pend   | up_edge;
      down_pend <= down_pend | dn_edge;
      col_pend  <= col_pend  | collide;
      pass_pend <= pass_pend | pipe_passed;
    end
  end

  // Game state registers, advanced only on an enabled frame tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      bird_y    <= Y_START;
      vel       <= '0;
      score     <= '0;
      cnt       <= '0;
    end else if (tick) begin
      cur_state <= nxt_state;
      bird_y    <= y_n;
      vel       <= vel_n;
      score     <= score_n;
      cnt       <= cnt_n;
    end
  end

  // Next-frame state, physics and scoring
  always_comb begin
    nxt_state = cur_state;
    y_n       = bird_y;
    vel_n     = vel;
    score_n   = score;
    cnt_n     = cnt;
    vel_grav  = 6'(vel) + V_GRAV;
    vel_sel   = '0;
    y_sum     = '0;

    case (cur_state)
      S_IDLE: begin
        y_n   = Y_START;
        vel_n = '0;
        if (up_pend) begin
          nxt_state = S_PLAY;
          vel_n     = 5'(V_FLAP);
          score_n   = '0;
        end
      end

      S_PLAY: begin
        if (col_pend || bird_y == Y_MAX) begin
          nxt_state = S_DYING;
          cnt_n     = CNT_INIT;
        end else begin
          if (up_pend)                vel_sel = V_FLAP;
          else if (down_pend)         vel_sel = V_MAX;
          else if (vel_grav > V_MAX)  vel_sel = V_MAX;
          else                        vel_sel = vel_grav;
          vel_n = vel_sel[4:0];

          // Signed add in 11 bits so the ceiling clamps instead of wrapping
          y_sum = $signed({1'b0, bird_y}) + 11'(vel_sel);
          if (y_sum < 11'sd0)                          y_n = '0;
          else if (y_sum > $signed({1'b0, Y_MAX}))     y_n = Y_MAX;
          else                                         y_n = y_sum[9:0];

          if (pass_pend && score != 8'h99) begin
            if (score[3:0] == 4'd9) score_n = {score[7:4] + 4'd1, 4'd0};
            else                    score_n = {score[7:4], score[3:0] + 4'd1};
          end
        end
      end

      S_DYING: begin
        y_sum = $signed({1'b0, bird_y}) + 11'(V_MAX);
        if (y_sum > $signed({1'b0, Y_MAX})) y_n = Y_MAX;
        else                                y_n = y_sum[9:0];
        if (cnt == '0) nxt_state = S_OVER;
        else           cnt_n     = cnt - CNT_W'(1);
      end

      S_OVER: begin
        if (up_pend) begin
          nxt_state = S_IDLE;
          y_n       = Y_START;
          vel_n     = '0;
        end
      end

      default: nxt_state = S_IDLE;
    endcase
  end

  assign state     = cur_state;
  assign scroll_en = (cur_state == S_PLAY);
  assign game_over = (cur_state == S_OVER);
  assign flash     = (cur_state == S_DYING) & cnt[3];

endmodule
